// File: rtl/spike_count_decoder_pkg.sv
// Shared FSM type, default widths and saturation helper for the SNN output spike decoder.
package snn_decode_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_NUM_NEURONS = 100;
  localparam int DEF_COUNT_WIDTH = 16;
  localparam int DEF_LABEL_WIDTH = 4;
  localparam int DEF_INDEX_WIDTH = 7;

  function automatic longint unsigned sat_max(input int width);
    return (64'd1 << width) - 64'd1;
  endfunction

  localparam longint unsigned DEF_SAT_MAX = sat_max(DEF_COUNT_WIDTH);

endpackage

// File: rtl/spike_count_decoder_if.sv
// Decoder bus: spike/window inputs from the SNN core, and the result handshake to the consumer.
interface spike_count_decoder_if #(
  parameter int NUM_NEURONS = snn_decode_pkg::DEF_NUM_NEURONS,
  parameter int COUNT_WIDTH = snn_decode_pkg::DEF_COUNT_WIDTH,
  parameter int LABEL_WIDTH = snn_decode_pkg::DEF_LABEL_WIDTH,
  parameter int INDEX_WIDTH = snn_decode_pkg::DEF_INDEX_WIDTH
);
  logic                   en;
  logic [31:0]            cycles_before_new_image;
  logic [NUM_NEURONS-1:0] spikes_in;
  logic [LABEL_WIDTH-1:0] neuron_labels [NUM_NEURONS];
  logic                   result_ready;
  logic                   result_valid;
  logic [LABEL_WIDTH-1:0] result_label;
  logic [INDEX_WIDTH-1:0] result_neuron;
  logic [COUNT_WIDTH-1:0] result_count;
  logic                   no_spike;
  logic                   busy;
  logic                   overrun;

  modport master (
    output en, cycles_before_new_image, spikes_in, neuron_labels, result_ready,
    input  result_valid, result_label, result_neuron, result_count, no_spike, busy, overrun
  );

  modport slave (
    input  en, cycles_before_new_image, spikes_in, neuron_labels, result_ready,
    output result_valid, result_label, result_neuron, result_count, no_spike, busy, overrun
  );
endinterface

// File: rtl/spike_counter_bank.sv
// Per-neuron saturating live spike counters with a snapshot register bank.
// Latency: snapshot holds the count including the load-cycle spike; no backpressure.
module spike_counter_bank
  import snn_decode_pkg::*;
#(
  parameter int NUM_NEURONS = DEF_NUM_NEURONS,
  parameter int COUNT_WIDTH = DEF_COUNT_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic [NUM_NEURONS-1:0] spikes_in,
  input  logic                   clear,
  input  logic                   load,
  output logic [COUNT_WIDTH-1:0] snap [NUM_NEURONS]
);

  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = COUNT_WIDTH'(sat_max(COUNT_WIDTH));

  logic [COUNT_WIDTH-1:0] cnt     [NUM_NEURONS];
  logic [COUNT_WIDTH-1:0] cnt_nxt [NUM_NEURONS];

  always_comb begin
    for (int n = 0; n < NUM_NEURONS; n++) begin
      cnt_nxt[n] = cnt[n];
      if (en && spikes_in[n] && (cnt[n] != CNT_MAX)) begin
        cnt_nxt[n] = cnt[n] + COUNT_WIDTH'(1);
      end
    end
  end

  // The snapshot takes cnt_nxt so a spike landing on the window-end cycle is kept.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int n = 0; n < NUM_NEURONS; n++) begin
        cnt[n]  <= '0;
        snap[n] <= '0;
      end
    end else begin
      for (int n = 0; n < NUM_NEURONS; n++) begin
        cnt[n] <= clear ? '0 : cnt_nxt[n];
        if (load) begin
          snap[n] <= cnt_nxt[n];
        end
      end
    end
  end

endmodule

// File: rtl/spike_count_decoder.sv
// Window spike counter, argmax scan and label lookup; result valid NUM_NEURONS+1 cycles after window end.
// Result is held in DONE until accepted; a window ending while not IDLE is dropped and flags overrun.
module spike_count_decoder
  import snn_decode_pkg::*;
#(
  parameter int NUM_NEURONS = DEF_NUM_NEURONS,
  parameter int COUNT_WIDTH = DEF_COUNT_WIDTH,
  parameter int LABEL_WIDTH = DEF_LABEL_WIDTH,
  parameter int INDEX_WIDTH = DEF_INDEX_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  spike_count_decoder_if.slave  bus
);

  state_t                 state_q;
  state_t                 state_d;
  logic [31:0]            wcnt;
  logic                   window_end;
  logic                   snap_load;
  logic                   scan_last;
  logic                   cand_gt;
  logic [INDEX_WIDTH-1:0] idx_q;
  logic [INDEX_WIDTH-1:0] best_q;
  logic [INDEX_WIDTH-1:0] win_idx;
  logic [COUNT_WIDTH-1:0] bestcnt_q;
  logic [COUNT_WIDTH-1:0] cand_cnt;
  logic [COUNT_WIDTH-1:0] win_cnt;
  logic [COUNT_WIDTH-1:0] snap [NUM_NEURONS];
  logic [LABEL_WIDTH-1:0] label_q;
  logic [INDEX_WIDTH-1:0] neuron_q;
  logic [COUNT_WIDTH-1:0] count_q;
  logic                   no_spike_q;
  logic                   overrun_q;

  assign window_end = bus.en && (bus.cycles_before_new_image != 32'd0) &&
                      (wcnt == bus.cycles_before_new_image - 32'd1);

  always_ff @(posedge clk) begin
    if (reset) begin
      wcnt <= '0;
    end else if (window_end) begin
      wcnt <= '0;
    end else if (bus.en) begin
      wcnt <= wcnt + 32'd1;
    end
  end

  spike_counter_bank #(
    .NUM_NEURONS (NUM_NEURONS),
    .COUNT_WIDTH (COUNT_WIDTH)
  ) u_bank (
    .clk       (clk),
    .reset     (reset),
    .en        (bus.en),
    .spikes_in (bus.spikes_in),
    .clear     (window_end),
    .load      (snap_load),
    .snap      (snap)
  );

  // Strict compare keeps the earliest index on ties.
  assign scan_last = (idx_q == INDEX_WIDTH'(NUM_NEURONS - 1));
  assign cand_cnt  = snap[idx_q];
  assign cand_gt   = (cand_cnt > bestcnt_q);
  assign win_idx   = cand_gt ? idx_q : best_q;
  assign win_cnt   = cand_gt ? cand_cnt : bestcnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (window_end) state_d = SCAN;
      SCAN:    if (scan_last) state_d = DONE;
      DONE:    if (bus.result_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    snap_load        = window_end && (state_q == IDLE);
    bus.result_valid = (state_q == DONE);
    bus.busy         = (state_q != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q      <= '0;
      best_q     <= '0;
      bestcnt_q  <= '0;
      label_q    <= '0;
      neuron_q   <= '0;
      count_q    <= '0;
      no_spike_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      if (window_end && (state_q != IDLE)) begin
        overrun_q <= 1'b1;
      end
      if (snap_load) begin
        idx_q     <= '0;
        best_q    <= '0;
        bestcnt_q <= '0;
      end else if (state_q == SCAN) begin
        idx_q     <= idx_q + INDEX_WIDTH'(1);
        best_q    <= win_idx;
        bestcnt_q <= win_cnt;
        if (scan_last) begin
          neuron_q   <= win_idx;
          count_q    <= win_cnt;
          no_spike_q <= (win_cnt == '0);
          label_q    <= (win_cnt == '0) ? '0 : bus.neuron_labels[win_idx];
        end
      end
    end
  end

  assign bus.result_label  = label_q;
  assign bus.result_neuron = neuron_q;
  assign bus.result_count  = count_q;
  assign bus.no_spike      = no_spike_q;
  assign bus.overrun       = overrun_q;

endmodule
